// File: rtl/next_pc_unit.sv
// Next-PC selection with a small trap unit (illegal, ERET, optional external interrupt).
// Define NEXT_PC_IRQ_EN to enable the IRQ latch and interrupt trap path.
module next_pc_unit #(
   parameter int unsigned WL       = 32,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [WL-1:0] pc_i,
   input  logic          branch_i,
   input  logic          zero_i,
   input  logic          jump_i,
   input  logic          jump_reg_i,
   input  logic [WL-1:0] ext_imm_i,
   input  logic [25:0]   j_target_i,
   input  logic [WL-1:0] reg_target_i,
   input  logic          stall_i,
   input  logic          illegal_i,
   input  logic          eret_i,
   input  logic          irq_i,
   output logic [WL-1:0] next_pc_o,
   output logic [WL-1:0] epc_o,
   output logic [1:0]    cause_o,
   output logic          in_handler_o,
   output logic          irq_pending_o
);

   localparam logic [WL-1:0] TrapVec = WL'(TRAP_VEC);

   localparam logic [1:0] CauseNone    = 2'b00;
   localparam logic [1:0] CauseIllegal = 2'b01;
   localparam logic [1:0] CauseIrq     = 2'b10;
   localparam logic [1:0] CauseDouble  = 2'b11;

   typedef enum logic [0:0] {StNormal, StHandler} state_e;

   state_e        state_q;
   logic [WL-1:0] epc_q;
   logic [1:0]    cause_q;
   logic          irq_pending;

   logic [WL-1:0] pc_plus4;
   logic [WL-1:0] branch_tgt;
   logic [WL-1:0] jump_tgt;
   logic [WL-1:0] sel_pc;
   logic          in_normal;
   logic          trap_ill;
   logic          trap_dbl;
   logic          trap_irq;
   logic          do_eret;

   assign in_normal = (state_q == StNormal);

   always_comb begin
      pc_plus4   = pc_i + WL'(4);
      branch_tgt = pc_plus4 + (ext_imm_i << 2);
      // Upper bits above the 28-bit jump region come from PC+4.
      jump_tgt   = ((pc_plus4 >> 28) << 28) | WL'({j_target_i, 2'b00});

      trap_ill = !stall_i && illegal_i && in_normal;
      trap_dbl = !stall_i && illegal_i && !in_normal;
      trap_irq = !stall_i && !illegal_i && irq_pending && in_normal;
      do_eret  = !stall_i && !illegal_i && !trap_irq && eret_i && !in_normal;

      sel_pc = pc_plus4;
      if (stall_i) begin
         sel_pc = pc_i;
      end else if (trap_ill || trap_dbl || trap_irq) begin
         sel_pc = TrapVec;
      end else if (do_eret) begin
         sel_pc = epc_q;
      end else if (jump_reg_i) begin
         sel_pc = reg_target_i;
      end else if (jump_i) begin
         sel_pc = jump_tgt;
      end else if (branch_i && zero_i) begin
         sel_pc = branch_tgt;
      end
   end

   assign next_pc_o = RST ? '0 : sel_pc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StNormal;
         epc_q   <= '0;
         cause_q <= CauseNone;
      end else if (trap_ill) begin
         state_q <= StHandler;
         epc_q   <= pc_i;
         cause_q <= CauseIllegal;
      end else if (trap_dbl) begin
         cause_q <= CauseDouble;
      end else if (trap_irq) begin
         state_q <= StHandler;
         epc_q   <= pc_i;
         cause_q <= CauseIrq;
      end else if (do_eret) begin
         state_q <= StNormal;
         cause_q <= CauseNone;
      end
   end

`ifdef NEXT_PC_IRQ_EN
   logic irq_pending_q;

   // Clearing on the service edge takes precedence over a fresh request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         irq_pending_q <= 1'b0;
      end else if (trap_irq) begin
         irq_pending_q <= 1'b0;
      end else if (irq_i) begin
         irq_pending_q <= 1'b1;
      end
   end

   assign irq_pending = irq_pending_q;
`else
   logic unused_irq;
   assign unused_irq  = irq_i;
   assign irq_pending = 1'b0;
`endif

   assign epc_o         = epc_q;
   assign cause_o       = cause_q;
   assign in_handler_o  = (state_q == StHandler);
   assign irq_pending_o = irq_pending;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed scoreboard bench for next_pc_unit; expectations follow NEXT_PC_IRQ_EN.
module tb_next_pc_unit;

   localparam int unsigned WL = 32;
`ifdef NEXT_PC_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   localparam int KNpc = 0;
   localparam int KEpc = 1;
   localparam int KCause = 2;
   localparam int KInh = 3;
   localparam int KIrqp = 4;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] val;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [WL-1:0] pc;
   logic          branch;
   logic          zero;
   logic          jump;
   logic          jump_reg;
   logic [WL-1:0] ext_imm;
   logic [25:0]   j_target;
   logic [WL-1:0] reg_target;
   logic          stall;
   logic          illegal;
   logic          eret;
   logic          irq;
   logic [WL-1:0] next_pc;
   logic [WL-1:0] epc;
   logic [1:0]    cause;
   logic          in_handler;
   logic          irq_pending;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   next_pc_unit #(.WL(WL), .TRAP_VEC(32'h0000_0080)) dut (
      .CLK           (clk),
      .RST           (rst),
      .pc_i          (pc),
      .branch_i      (branch),
      .zero_i        (zero),
      .jump_i        (jump),
      .jump_reg_i    (jump_reg),
      .ext_imm_i     (ext_imm),
      .j_target_i    (j_target),
      .reg_target_i  (reg_target),
      .stall_i       (stall),
      .illegal_i     (illegal),
      .eret_i        (eret),
      .irq_i         (irq),
      .next_pc_o     (next_pc),
      .epc_o         (epc),
      .cause_o       (cause),
      .in_handler_o  (in_handler),
      .irq_pending_o (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_in();
      branch = 0; zero = 0; jump = 0; jump_reg = 0; ext_imm = '0; j_target = '0;
      reg_target = '0; stall = 0; illegal = 0; eret = 0; irq = 0;
   endtask

   task automatic push(input string tag, input int kind, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.val = val;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         KNpc:    return next_pc;
         KEpc:    return epc;
         KCause:  return {30'd0, cause};
         KInh:    return {31'd0, in_handler};
         default: return {31'd0, irq_pending};
      endcase
   endfunction

   // Pops every pending expectation and compares it against the live DUT outputs.
   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.kind);
         checks++;
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic regs(input string tag, input logic [31:0] e_epc, input logic [1:0] e_cause,
                       input logic e_inh, input logic e_irqp);
      push({tag, "_epc"}, KEpc, e_epc);
      push({tag, "_cause"}, KCause, {30'd0, e_cause});
      push({tag, "_inh"}, KInh, {31'd0, e_inh});
      push({tag, "_irqp"}, KIrqp, {31'd0, e_irqp});
      check();
   endtask

   initial begin
      clear_in();
      pc  = 32'h0;
      rst = 1'b1;
      @(negedge clk);
      push("rst_npc", KNpc, 32'h0); check();
      step();
      regs("rst", 32'h0, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;

      pc = 32'h100; push("seq", KNpc, 32'h104); check();
      pc = 32'hFFFF_FFFC; push("seq_wrap", KNpc, 32'h0); check();

      pc = 32'h200; branch = 1; zero = 1; ext_imm = 32'hFFFF_FFFE;
      push("br_taken", KNpc, 32'h1FC); check();
      zero = 0; push("br_not", KNpc, 32'h204); check();
      clear_in();

      pc = 32'h1000_0000; j_target = 26'h10; jump = 1;
      push("jump", KNpc, 32'h1000_0040); check();
      jump_reg = 1; reg_target = 32'h300; push("jreg_prio", KNpc, 32'h300); check();
      clear_in();

      pc = 32'h700; eret = 1; push("eret_normal", KNpc, 32'h704); check();
      step(); regs("eret_normal", 32'h0, 2'b00, 1'b0, 1'b0);
      clear_in();

      pc = 32'h400; illegal = 1; push("ill", KNpc, 32'h80); check();
      step(); regs("ill", 32'h400, 2'b01, 1'b1, 1'b0);
      clear_in();

      pc = 32'h80; eret = 1; push("eret", KNpc, 32'h400); check();
      step(); regs("eret", 32'h400, 2'b00, 1'b0, 1'b0);
      clear_in();

      pc = 32'h400; illegal = 1; push("ill2", KNpc, 32'h80); check();
      step(); regs("ill2", 32'h400, 2'b01, 1'b1, 1'b0);
      pc = 32'h84; push("dbl", KNpc, 32'h80); check();
      step(); regs("dbl", 32'h400, 2'b11, 1'b1, 1'b0);
      clear_in();

      pc = 32'h90; irq = 1; push("irq_masked", KNpc, 32'h94); check();
      step(); regs("irq_set", 32'h400, 2'b11, 1'b1, IrqEn);
      irq = 0; pc = 32'h94; step();
      regs("irq_hold", 32'h400, 2'b11, 1'b1, IrqEn);

      pc = 32'h98; eret = 1; push("eret_irq", KNpc, 32'h400); check();
      step(); regs("eret_irq", 32'h400, 2'b00, 1'b0, IrqEn);
      clear_in();

      pc = 32'h500; push("irq_trap", KNpc, IrqEn ? 32'h80 : 32'h504); check();
      step();
      regs("irq_trap", IrqEn ? 32'h500 : 32'h400, IrqEn ? 2'b10 : 2'b00, IrqEn, 1'b0);

      pc = 32'h80; eret = 1; push("eret2", KNpc, IrqEn ? 32'h500 : 32'h84); check();
      step(); regs("eret2", IrqEn ? 32'h500 : 32'h400, 2'b00, 1'b0, 1'b0);
      clear_in();

      pc = 32'h600; stall = 1; illegal = 1; push("stall_ill", KNpc, 32'h600); check();
      step(); regs("stall_ill", IrqEn ? 32'h500 : 32'h400, 2'b00, 1'b0, 1'b0);
      clear_in();

      pc = 32'h610; stall = 1; irq = 1; push("stall_irq", KNpc, 32'h610); check();
      step(); regs("stall_irq", IrqEn ? 32'h500 : 32'h400, 2'b00, 1'b0, IrqEn);
      stall = 0; pc = 32'h614;
      push("irq_trap2", KNpc, IrqEn ? 32'h80 : 32'h618); check();
      step();
      regs("clear_wins", IrqEn ? 32'h614 : 32'h400, IrqEn ? 2'b10 : 2'b00, IrqEn, 1'b0);
      clear_in();

      pc = 32'h620; illegal = 1; irq = 1; push("ill3", KNpc, 32'h80); check();
      step();
      regs("ill3", IrqEn ? 32'h614 : 32'h620, IrqEn ? 2'b11 : 2'b01, 1'b1, IrqEn);
      clear_in();

      rst = 1; pc = 32'h624; push("rst_mid_npc", KNpc, 32'h0); check();
      step(); regs("rst_mid", 32'h0, 2'b00, 1'b0, 1'b0);
      rst = 0;
      pc = 32'h100; push("post_rst", KNpc, 32'h104); check();
      step(); regs("post_rst", 32'h0, 2'b00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
